// File: rtl/rvga_muldiv.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add mul, restoring div/rem).
// Latency: WIDTH BUSY cycles after accept; div-by-zero and signed overflow finish in one cycle.
// Backpressure: ready_o only in IDLE; the result is held on o with v_o=1 until yumi_i.
//
// Ports:
//   clk_i, reset_n_i    clock and synchronous active-low reset
//   v_i / ready_o       request handshake carrying a_i, b_i and op_i (RV32M funct3)
//   v_o / o / yumi_i    result valid, result value, and consumer acknowledge
module rvga_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             v_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             v_o,
    output logic [WIDTH-1:0] o,
    input  logic             yumi_i
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               sa_q, sa_d;        // sign of a (remainder sign)
    logic               neg_q, neg_d;      // sign of product / quotient
    logic [WIDTH-1:0]   mcand_q, mcand_d;  // |b|: multiplicand or divisor
    logic [2*WIDTH-1:0] prod_q, prod_d;    // {high accumulator, remaining multiplier bits}
    logic [WIDTH:0]     rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   res_q, res_d;

    // Operand decode at accept
    logic               a_signed, b_signed, sa_in, sb_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   special_res;

    // One datapath step, computed from current state
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step, prod_fix;
    logic [WIDTH:0]     div_shift, div_diff, rem_step;
    logic [WIDTH-1:0]   quo_step, quo_fix, rem_fix;
    logic [WIDTH-1:0]   final_res;

    // a is signed for mul, mulh, mulhsu, div, rem; b for mul, mulh, div, rem
    assign a_signed = ~op_i[0] | (op_i == 3'd1);
    assign b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign sa_in    = a_signed & a_i[WIDTH-1];
    assign sb_in    = b_signed & b_i[WIDTH-1];
    assign a_mag    = sa_in ? -a_i : a_i;
    assign b_mag    = sb_in ? -b_i : b_i;

    assign div_zero = op_i[2] && (b_i == '0);
    // div and rem are the even div-group opcodes
    assign div_ovf  = op_i[2] && !op_i[0]
                   && (a_i == {1'b1, {(WIDTH-1){1'b0}}})
                   && (b_i == {WIDTH{1'b1}});

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? a_i : {WIDTH{1'b1}};
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : a_i;
        end
    end

    // Multiply step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring divide step: a negative trial difference means restore.
    assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign rem_step  = div_diff[WIDTH] ? div_shift : div_diff;
    assign quo_step  = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    // Sign correction applied to the last step's output so the final edge
    // both performs the last iteration and loads the corrected result.
    assign prod_fix  = neg_q ? -prod_step : prod_step;
    assign quo_fix   = neg_q ? -quo_step : quo_step;
    assign rem_fix   = sa_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

    always_comb begin
        final_res = '0;
        case (op_q)
            3'd0:                final_res = prod_fix[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          final_res = quo_fix;
            default:             final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (v_i) begin
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        state_d = S_DONE;
                    end else begin
                        op_d    = op_i;
                        sa_d    = sa_in;
                        neg_d   = sa_in ^ sb_in;
                        mcand_d = b_mag;
                        prod_d  = {{WIDTH{1'b0}}, a_mag};
                        rem_d   = '0;
                        quo_d   = a_mag;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (op_q[2]) begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                end else begin
                    prod_d = prod_step;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    res_d   = final_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A concurrent v_i is not accepted here; IDLE must be seen first.
                if (yumi_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign v_o     = (state_q == S_DONE);
    assign o       = res_q;

endmodule

// File: tb/tb_rvga_muldiv.sv
// Directed bench for rvga_muldiv: stimulus pushes expected results into a
// scoreboard queue; a negedge monitor pops and checks value and latency on
// each rising v_o. Latency is counted in clock edges after the accept edge.
module tb_rvga_muldiv;

    logic        clk;
    logic        reset_n;
    logic        v_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [2:0]  op_i;
    logic        v_o;
    logic [31:0] o;
    logic        yumi_i;

    rvga_muldiv #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .op_i      (op_i),
        .v_o       (v_o),
        .o         (o),
        .yumi_i    (yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic v_prev = 1'b0;

    // Monitor
    always @(negedge clk) begin
        if (reset_n && v_o && !v_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: o=%h with empty scoreboard", o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s value: got %h expected %h", e.name, o, e.val);
                end
                checks++;
                if ((cyc - e.acc) != e.lat) begin
                    errors++;
                    $display("FAIL %s latency: got %0d expected %0d", e.name, cyc - e.acc, e.lat);
                end
            end
        end
        v_prev = v_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge while the unit is idle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string nm, input bit push);
        op_i = op;
        a_i  = a;
        b_i  = b;
        v_i  = 1'b1;
        if (push) sb_q.push_back('{exp, lat, cyc + 1, nm});
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!v_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!v_o) begin
            errors++;
            $display("FAIL %s timeout: v_o=%b expected 1 within 100 cycles", nm, v_o);
        end
    endtask

    // Hold the result for 'hold' cycles (with v_i pulses), then acknowledge
    // with v_i also high to exercise the DONE boundary.
    task automatic consume(input int hold, input string nm);
        logic [31:0] o0;
        o0 = o;
        for (int i = 0; i < hold; i++) begin
            v_i = i[0];
            @(posedge clk); #1;
            chk({nm, " hold_o"}, o, o0);
            chk({nm, " hold_vo_rdy"}, {31'd0, v_o & ~ready_o}, 32'd1);
        end
        yumi_i = 1'b1;
        v_i    = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        v_i    = 1'b0;
        chk({nm, " release_rdy_vo"}, {30'd0, ready_o, v_o}, 32'd2);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm);
        issue(op, a, b, exp, lat, nm, 1'b1);
        wait_done(nm);
        consume(0, nm);
    endtask

    initial begin
        reset_n = 1'b0;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        a_i     = '0;
        b_i     = '0;
        op_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, ready_o, v_o, |o}, 32'd4);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Multiply; first one also exercises a long hold with ignored v_i.
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32, "mul_7x-3", 1'b1);
        chk("busy_not_ready", {31'd0, ready_o}, 32'd0);
        wait_done("mul_7x-3");
        consume(10, "mul_7x-3");
        run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32, "mulh_min_min");
        run(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 32, "mulhu_2^31");
        run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, "mulhsu_-1");
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, "mulhu_max");
        run(3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 32, "mul_shift");

        // Divide / remainder
        run(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, "div_-7/2");
        run(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, "rem_-7/2");
        run(3'd5, 32'd100, 32'd7, 32'd14, 32, "divu_100/7");
        run(3'd7, 32'd100, 32'd7, 32'd2, 32, "remu_100/7");
        run(3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32, "rem_-7/-2");
        run(3'd5, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32, "divu_max/1");

        // Special cases finish one cycle after accept
        run(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "div_by_0");
        run(3'd7, 32'd5, 32'd0, 32'd5, 0, "remu_by_0");
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, "rem_ovf");

        // Reset mid-BUSY (counter at 10) aborts; no result is expected.
        issue(3'd5, 32'd9, 32'd3, 32'd3, 32, "aborted", 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_state", {29'd0, ready_o, v_o, |o}, 32'd4);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run(3'd5, 32'd9, 32'd3, 32'd3, 32, "divu_9/3_after_abort");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
